// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Message codes, channel ids and FSM state encoding shared by the
//            main-memory port arbiter and its bench.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int          C_CODE_BITS = 3;

    localparam logic [C_CODE_BITS-1:0] NO_REQ  = 3'd0;
    localparam logic [C_CODE_BITS-1:0] R_REQ   = 3'd1;
    localparam logic [C_CODE_BITS-1:0] WB_REQ  = 3'd2;
    localparam logic [C_CODE_BITS-1:0] R_RESP  = 3'd4;
    localparam logic [C_CODE_BITS-1:0] WB_RESP = 3'd5;

    localparam logic CH_IFACE = 1'b0;
    localparam logic CH_LXB   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant; combinational grant, registered pointer
//            moved to the channel other than the finishing owner on update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic [1:0] grant
);

    logic r_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= CH_IFACE;
        end else if (update) begin
            r_ptr <= ~owner;
        end
    end

    // A lone requester wins regardless of where the pointer sits.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_ptr == CH_LXB) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Merges the L2 memory interface and L2 bypass onto one main-memory
//            port, one transaction at a time, routing responses to the owner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MSG_BITS       = 3,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      interface2arb_msg,
    input  logic [ADDRESS_WIDTH-1:0] interface2arb_address,
    input  logic [DATA_WIDTH-1:0]    interface2arb_data,
    output logic [MSG_BITS-1:0]      arb2interface_msg,
    output logic [ADDRESS_WIDTH-1:0] arb2interface_address,
    output logic [DATA_WIDTH-1:0]    arb2interface_data,
    input  logic [MSG_BITS-1:0]      lxb2arb_msg,
    input  logic [ADDRESS_WIDTH-1:0] lxb2arb_address,
    input  logic [DATA_WIDTH-1:0]    lxb2arb_data,
    output logic [MSG_BITS-1:0]      arb2lxb_msg,
    output logic [ADDRESS_WIDTH-1:0] arb2lxb_address,
    output logic [DATA_WIDTH-1:0]    arb2lxb_data,
    output logic [MSG_BITS-1:0]      arb2mem_msg,
    output logic [ADDRESS_WIDTH-1:0] arb2mem_address,
    output logic [DATA_WIDTH-1:0]    arb2mem_data,
    input  logic [MSG_BITS-1:0]      mem2arb_msg,
    input  logic [ADDRESS_WIDTH-1:0] mem2arb_address,
    input  logic [DATA_WIDTH-1:0]    mem2arb_data,
    output logic                     timeout_err
);

    localparam logic [MSG_BITS-1:0] c_no_req   = MSG_BITS'(NO_REQ);
    localparam logic [15:0]         c_timeout  = 16'(TIMEOUT_CYCLES);
    localparam logic                c_wd_en    = (TIMEOUT_CYCLES != 0);

    arb_state_t r_state, w_state_next;
    logic       r_owner;
    logic [1:0] w_req, w_grant;
    logic       w_grant_en, w_resp_en, w_drain_done;
    logic [MSG_BITS-1:0] w_owner_msg;

    logic [MSG_BITS-1:0]      r_mem_msg,  r_if_msg,  r_lxb_msg;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr, r_if_addr, r_lxb_addr;
    logic [DATA_WIDTH-1:0]    r_mem_data, r_if_data, r_lxb_data;
    logic [15:0]              r_wd_cnt, w_wd_inc;
    logic                     r_timeout;

    assign w_req       = {lxb2arb_msg != c_no_req, interface2arb_msg != c_no_req};
    assign w_owner_msg = (r_owner == CH_LXB) ? lxb2arb_msg : interface2arb_msg;
    assign w_wd_inc    = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;

    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    (w_req),
        .update (w_drain_done),
        .owner  (r_owner),
        .grant  (w_grant)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        w_resp_en    = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_grant_en   = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem2arb_msg != c_no_req) begin
                    w_resp_en    = 1'b1;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_owner_msg == c_no_req) begin
                    w_drain_done = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner    <= CH_IFACE;
            r_mem_msg  <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_if_msg   <= '0;
            r_if_addr  <= '0;
            r_if_data  <= '0;
            r_lxb_msg  <= '0;
            r_lxb_addr <= '0;
            r_lxb_data <= '0;
        end else begin
            if (w_grant_en) begin
                r_owner <= w_grant[1];
                if (w_grant[1]) begin
                    r_mem_msg  <= lxb2arb_msg;
                    r_mem_addr <= lxb2arb_address;
                    r_mem_data <= lxb2arb_data;
                end else begin
                    r_mem_msg  <= interface2arb_msg;
                    r_mem_addr <= interface2arb_address;
                    r_mem_data <= interface2arb_data;
                end
            end
            if (w_resp_en) begin
                r_mem_msg  <= '0;
                r_mem_addr <= '0;
                r_mem_data <= '0;
                if (r_owner == CH_LXB) begin
                    r_lxb_msg  <= mem2arb_msg;
                    r_lxb_addr <= mem2arb_address;
                    r_lxb_data <= mem2arb_data;
                end else begin
                    r_if_msg   <= mem2arb_msg;
                    r_if_addr  <= mem2arb_address;
                    r_if_data  <= mem2arb_data;
                end
            end
            if (w_drain_done) begin
                r_if_msg   <= '0;
                r_if_addr  <= '0;
                r_if_data  <= '0;
                r_lxb_msg  <= '0;
                r_lxb_addr <= '0;
                r_lxb_data <= '0;
            end
        end
    end

    // Watchdog only flags a stuck memory; the transaction keeps waiting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_grant_en) begin
            r_wd_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_wd_cnt <= w_wd_inc;
            if (c_wd_en && (w_wd_inc == c_timeout)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign arb2mem_msg           = r_mem_msg;
    assign arb2mem_address       = r_mem_addr;
    assign arb2mem_data          = r_mem_data;
    assign arb2interface_msg     = r_if_msg;
    assign arb2interface_address = r_if_addr;
    assign arb2interface_data    = r_if_data;
    assign arb2lxb_msg           = r_lxb_msg;
    assign arb2lxb_address       = r_lxb_addr;
    assign arb2lxb_data          = r_lxb_data;
    assign timeout_err           = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter with a queue of
//            expected main-memory requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic [2:0]  msg;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clock, reset;
    logic [2:0]  interface2arb_msg, arb2interface_msg, lxb2arb_msg, arb2lxb_msg;
    logic [2:0]  arb2mem_msg, mem2arb_msg;
    logic [31:0] interface2arb_address, interface2arb_data;
    logic [31:0] arb2interface_address, arb2interface_data;
    logic [31:0] lxb2arb_address, lxb2arb_data, arb2lxb_address, arb2lxb_data;
    logic [31:0] arb2mem_address, arb2mem_data, mem2arb_address, mem2arb_data;
    logic        timeout_err;

    int   checks = 0;
    int   errors = 0;
    req_t exp_q[$];

    mem_port_arbiter #(
        .MSG_BITS       (3),
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .interface2arb_msg     (interface2arb_msg),
        .interface2arb_address (interface2arb_address),
        .interface2arb_data    (interface2arb_data),
        .arb2interface_msg     (arb2interface_msg),
        .arb2interface_address (arb2interface_address),
        .arb2interface_data    (arb2interface_data),
        .lxb2arb_msg           (lxb2arb_msg),
        .lxb2arb_address       (lxb2arb_address),
        .lxb2arb_data          (lxb2arb_data),
        .arb2lxb_msg           (arb2lxb_msg),
        .arb2lxb_address       (arb2lxb_address),
        .arb2lxb_data          (arb2lxb_data),
        .arb2mem_msg           (arb2mem_msg),
        .arb2mem_address       (arb2mem_address),
        .arb2mem_data          (arb2mem_data),
        .mem2arb_msg           (mem2arb_msg),
        .mem2arb_address       (mem2arb_address),
        .mem2arb_data          (mem2arb_data),
        .timeout_err           (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag);
        req_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_msg"},  32'(arb2mem_msg), 32'(e.msg));
            chk({tag, "_addr"}, arb2mem_address,  e.addr);
            chk({tag, "_data"}, arb2mem_data,     e.data);
        end
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (arb2mem_msg == NO_REQ && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant_seen"}, 32'(arb2mem_msg != NO_REQ), 32'd1);
        check_req(tag);
    endtask

    task automatic respond(input logic [31:0] addr, input logic [31:0] data);
        mem2arb_msg     = R_RESP;
        mem2arb_address = addr;
        mem2arb_data    = data;
        tick();
        mem2arb_msg     = NO_REQ;
        mem2arb_address = '0;
        mem2arb_data    = '0;
    endtask

    initial begin
        int ki, kb;
        logic own_lxb;

        // Reset with random inputs
        reset                 = 1'b0;
        interface2arb_msg     = 3'($urandom);
        interface2arb_address = $urandom;
        interface2arb_data    = $urandom;
        lxb2arb_msg           = 3'($urandom);
        lxb2arb_address       = $urandom;
        lxb2arb_data          = $urandom;
        mem2arb_msg           = 3'($urandom);
        mem2arb_address       = $urandom;
        mem2arb_data          = $urandom;
        tick();
        tick();
        chk("rst_if_msg",   32'(arb2interface_msg), 32'd0);
        chk("rst_if_data",  arb2interface_data,     32'd0);
        chk("rst_lxb_msg",  32'(arb2lxb_msg),       32'd0);
        chk("rst_lxb_addr", arb2lxb_address,        32'd0);
        chk("rst_mem_msg",  32'(arb2mem_msg),       32'd0);
        chk("rst_mem_addr", arb2mem_address,        32'd0);
        chk("rst_timeout",  32'(timeout_err),       32'd0);
        interface2arb_msg = NO_REQ; interface2arb_address = '0; interface2arb_data = '0;
        lxb2arb_msg = NO_REQ; lxb2arb_address = '0; lxb2arb_data = '0;
        mem2arb_msg = NO_REQ; mem2arb_address = '0; mem2arb_data = '0;
        reset = 1'b1;
        tick(); tick(); tick();
        chk("idle_mem_msg", 32'(arb2mem_msg), 32'd0);

        // Interface alone
        interface2arb_msg     = R_REQ;
        interface2arb_address = 32'h100;
        exp_q.push_back('{R_REQ, 32'h100, 32'h0});
        tick();
        check_req("t2_req");
        tick(); tick(); tick();
        chk("t2_busy_if_msg", 32'(arb2interface_msg), 32'd0);
        respond(32'h100, 32'hDEADBEEF);
        chk("t2_if_data",  arb2interface_data,     32'hDEADBEEF);
        chk("t2_if_msg",   32'(arb2interface_msg), 32'(R_RESP));
        chk("t2_mem_idle", 32'(arb2mem_msg),       32'd0);
        chk("t2_lxb_zero", arb2lxb_data,           32'd0);
        tick();
        chk("t2_if_hold",  arb2interface_data,     32'hDEADBEEF);
        interface2arb_msg = NO_REQ;
        tick();
        chk("t2_if_clr",   arb2interface_data,     32'd0);
        chk("t2_if_clr_m", 32'(arb2interface_msg), 32'd0);

        // Simultaneous requests after a fresh reset: interface first
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        interface2arb_msg = WB_REQ; interface2arb_address = 32'h40; interface2arb_data = 32'h1111;
        lxb2arb_msg       = R_REQ;  lxb2arb_address       = 32'h80; lxb2arb_data       = 32'h0;
        exp_q.push_back('{WB_REQ, 32'h40, 32'h1111});
        exp_q.push_back('{R_REQ,  32'h80, 32'h0});
        tick();
        check_req("t3_first");
        chk("t3_lxb_quiet", 32'(arb2lxb_msg), 32'd0);
        respond(32'h40, 32'hAAAA0001);
        chk("t3_if_data",   arb2interface_data, 32'hAAAA0001);
        chk("t3_lxb_still", arb2lxb_data,       32'd0);
        interface2arb_msg = NO_REQ;
        tick();
        chk("t3_if_clr", 32'(arb2interface_msg), 32'd0);
        wait_grant("t3_second");
        respond(32'h80, 32'hBBBB0002);
        chk("t3_lxb_data",  arb2lxb_data,       32'hBBBB0002);
        chk("t3_if_quiet",  arb2interface_data, 32'd0);
        lxb2arb_msg = NO_REQ;
        tick();

        // Fairness: both keep requesting, grants must alternate I,B,I,B,I,B
        ki = 0;
        kb = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{R_REQ, 32'h1000 + 32'(i), 32'h0});
            exp_q.push_back('{R_REQ, 32'h2000 + 32'(i), 32'h0});
        end
        interface2arb_msg = R_REQ; interface2arb_address = 32'h1000; interface2arb_data = '0;
        lxb2arb_msg       = R_REQ; lxb2arb_address       = 32'h2000; lxb2arb_data       = '0;
        for (int t = 0; t < 6; t++) begin
            wait_grant($sformatf("t4_txn%0d", t));
            own_lxb = (arb2mem_address[15:12] == 4'h2);
            respond(arb2mem_address, 32'hC0DE0000 + 32'(t));
            if (own_lxb) begin
                chk($sformatf("t4_lxb_resp%0d", t), arb2lxb_data, 32'hC0DE0000 + 32'(t));
                chk($sformatf("t4_if_quiet%0d", t), arb2interface_data, 32'd0);
                lxb2arb_msg = NO_REQ;
                tick();
                kb++;
                lxb2arb_msg = R_REQ; lxb2arb_address = 32'h2000 + 32'(kb);
            end else begin
                chk($sformatf("t4_if_resp%0d", t), arb2interface_data, 32'hC0DE0000 + 32'(t));
                chk($sformatf("t4_lxb_quiet%0d", t), arb2lxb_data, 32'd0);
                interface2arb_msg = NO_REQ;
                tick();
                ki++;
                interface2arb_msg = R_REQ; interface2arb_address = 32'h1000 + 32'(ki);
            end
        end
        interface2arb_msg = NO_REQ;
        lxb2arb_msg       = NO_REQ;
        tick(); tick(); tick();

        // Spurious memory response while idle, then address change mid-BUSY
        mem2arb_msg = R_RESP; mem2arb_address = 32'h77; mem2arb_data = 32'h5555;
        tick(); tick();
        chk("t5_if_msg",  32'(arb2interface_msg), 32'd0);
        chk("t5_lxb_msg", 32'(arb2lxb_msg),       32'd0);
        chk("t5_mem_msg", 32'(arb2mem_msg),       32'd0);
        mem2arb_msg = NO_REQ; mem2arb_address = '0; mem2arb_data = '0;
        tick();
        interface2arb_msg = R_REQ; interface2arb_address = 32'h300;
        exp_q.push_back('{R_REQ, 32'h300, 32'h0});
        tick();
        check_req("t5_req");
        interface2arb_address = 32'h3FC;
        tick(); tick();
        chk("t5_addr_held", arb2mem_address, 32'h300);
        respond(32'h300, 32'h12345678);
        chk("t5_if_data", arb2interface_data, 32'h12345678);
        interface2arb_msg = NO_REQ;
        tick();
        chk("t5_no_timeout", 32'(timeout_err), 32'd0);

        // Watchdog with silent memory, then reset during DRAIN
        interface2arb_msg = R_REQ; interface2arb_address = 32'h400;
        exp_q.push_back('{R_REQ, 32'h400, 32'h0});
        tick();
        check_req("t6_req");
        for (int c = 0; c < 7; c++) tick();
        chk("t6_wd_7", 32'(timeout_err), 32'd0);
        tick();
        chk("t6_wd_8", 32'(timeout_err), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        chk("t6_wd_sticky", 32'(timeout_err), 32'd1);
        chk("t6_still_waiting", 32'(arb2mem_msg), 32'(R_REQ));
        respond(32'h400, 32'h0000600D);
        chk("t6_if_data", arb2interface_data, 32'h0000600D);
        chk("t6_wd_after", 32'(timeout_err), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_if_msg",  32'(arb2interface_msg), 32'd0);
        chk("t6_async_if_data", arb2interface_data,     32'd0);
        chk("t6_async_timeout", 32'(timeout_err),       32'd0);
        tick();
        interface2arb_msg = R_REQ; interface2arb_address = 32'h500;
        lxb2arb_msg       = R_REQ; lxb2arb_address       = 32'h600;
        exp_q.push_back('{R_REQ, 32'h500, 32'h0});
        reset = 1'b1;
        tick();
        check_req("t6_ptr_iface");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
